// File: rtl/lcd_string_writer_if.sv
// ---------------------------------------------------------------------------
// lcd_string_writer_if
// Bundles the string-buffer write port, the transfer handshake and the
// HD44780 parallel bus of lcd_string_writer.
//   AW        : width of wr_addr (max(1, $clog2(CHAR_COUNT)) of the writer)
//   wr_en     : buffer write strobe
//   wr_addr   : buffer index
//   wr_data   : ASCII code to store
//   start     : one-cycle request to send the whole buffer
//   busy      : transfer in progress
//   done      : one-cycle pulse at the end of a transfer
//   lcd_data  : HD44780 data bus
//   lcd_e     : HD44780 enable strobe
//   lcd_rw    : HD44780 read/write select (always write)
//   lcd_rs    : HD44780 register select (0 command, 1 character)
// master: the client that fills the buffer and requests transfers.
// slave : the writer itself.
// ---------------------------------------------------------------------------
interface lcd_string_writer_if #(
  parameter int unsigned AW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [7:0]    lcd_data;
  logic          lcd_e;
  logic          lcd_rw;
  logic          lcd_rs;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  busy, done, lcd_data, lcd_e, lcd_rw, lcd_rs
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output busy, done, lcd_data, lcd_e, lcd_rw, lcd_rs
  );
endinterface

// File: rtl/lcd_string_writer.sv
// ---------------------------------------------------------------------------
// lcd_string_writer
// Holds a CHAR_COUNT-character string buffer and, on request, writes it to an
// HD44780-style LCD: command 0x80, then the characters, with command 0xC0
// inserted before the first character of line 2. Each bus byte costs one
// SETUP cycle, E_HIGH_CYCLES cycles with lcd_e high and GAP_CYCLES low cycles.
//
// Optional feature (macro LCD_STRING_WRITER_CLEAR_EN): every transfer begins
// with the clear-display command 0x01, followed after its GAP by
// CLEAR_WAIT_CYCLES additional low cycles before the 0x80 command.
//
// Ports:
//   i_clk_1024 : clock, all logic on the rising edge
//   i_reset    : synchronous active-high reset; aborts any transfer and
//                fills the buffer with spaces (0x20)
//   io_bus     : lcd_string_writer_if.slave (write port, start/busy/done,
//                registered LCD bus)
// ---------------------------------------------------------------------------
module lcd_string_writer #(
  parameter int unsigned CHAR_COUNT        = 16,
  parameter int unsigned LINE_LEN          = 16,
  parameter int unsigned E_HIGH_CYCLES     = 1,
  parameter int unsigned GAP_CYCLES        = 2,
  parameter int unsigned CLEAR_WAIT_CYCLES = 3
) (
  input  logic                i_clk_1024,
  input  logic                i_reset,
  lcd_string_writer_if.slave  io_bus
);

  localparam int unsigned AW = (CHAR_COUNT > 1) ? $clog2(CHAR_COUNT) : 1;

  localparam int unsigned MaxEG = (E_HIGH_CYCLES > GAP_CYCLES) ? E_HIGH_CYCLES : GAP_CYCLES;
`ifdef LCD_STRING_WRITER_CLEAR_EN
  localparam int unsigned MaxCnt = (CLEAR_WAIT_CYCLES > MaxEG) ? CLEAR_WAIT_CYCLES : MaxEG;
`else
  localparam int unsigned MaxCnt = MaxEG;
`endif
  // Counter runs from N-1 down to 0, so it only has to hold MaxCnt-1.
  localparam int unsigned CW = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [CW-1:0] EHighLoad = CW'(E_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GapLoad   = CW'(GAP_CYCLES - 1);
`ifdef LCD_STRING_WRITER_CLEAR_EN
  localparam logic [CW-1:0] ClearLoad =
    CW'((CLEAR_WAIT_CYCLES > 0) ? CLEAR_WAIT_CYCLES - 1 : 0);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StEHigh,
    StGap,
`ifdef LCD_STRING_WRITER_CLEAR_EN
    StClearWait,
`endif
    StDone
  } state_e;

  // What the byte currently on the bus is.
  typedef enum logic [1:0] {
    KindClear,
    KindLine1,
    KindLine2,
    KindChar
  } kind_e;

  state_e         r_state;
  kind_e          r_kind;
  logic [AW-1:0]  r_char;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_lcd_e;
  logic           r_lcd_rs;
  logic [7:0]     r_lcd_data;
  logic [7:0]     r_buf [CHAR_COUNT];

  kind_e          w_nxt_kind;
  logic [AW-1:0]  w_nxt_char;
  logic           w_last;
  logic           w_nxt_rs;
  logic [7:0]     w_nxt_data;

  // -------------------------------------------------------------------------
  // String buffer: writable only while no transfer is running, so the
  // transfer can read it byte by byte without a snapshot.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk_1024) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < CHAR_COUNT; i++) begin
        r_buf[i] <= 8'h20;
      end
    end else if (io_bus.wr_en && !r_busy && (32'(io_bus.wr_addr) < CHAR_COUNT)) begin
      r_buf[io_bus.wr_addr] <= io_bus.wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Byte sequencer: which byte follows the one currently on the bus.
  // -------------------------------------------------------------------------
  always_comb begin
    w_last     = 1'b0;
    w_nxt_kind = r_kind;
    w_nxt_char = r_char;
    unique case (r_kind)
      KindClear: w_nxt_kind = KindLine1;
      KindLine1: begin
        w_nxt_kind = KindChar;
        w_nxt_char = '0;
      end
      KindLine2: w_nxt_kind = KindChar;
      default: begin
        if (32'(r_char) == CHAR_COUNT - 1) begin
          w_last = 1'b1;
        end else begin
          w_nxt_char = r_char + 1'b1;
          // Not the last character, so line 2 really exists here.
          if (32'(r_char) + 1 == LINE_LEN) begin
            w_nxt_kind = KindLine2;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_nxt_rs   = 1'b0;
    w_nxt_data = 8'h80;
    unique case (w_nxt_kind)
      KindClear: w_nxt_data = 8'h01;
      KindLine1: w_nxt_data = 8'h80;
      KindLine2: w_nxt_data = 8'hC0;
      default: begin
        w_nxt_rs   = 1'b1;
        w_nxt_data = r_buf[w_nxt_char];
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Bus FSM with registered outputs. Outputs change on the same edge as the
  // state, so each state's bus values are visible throughout that state.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk_1024) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_kind     <= KindLine1;
      r_char     <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_lcd_e    <= 1'b0;
      r_lcd_rs   <= 1'b0;
      r_lcd_data <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_state  <= StSetup;
            r_busy   <= 1'b1;
            r_char   <= '0;
            r_lcd_rs <= 1'b0;
`ifdef LCD_STRING_WRITER_CLEAR_EN
            r_kind     <= KindClear;
            r_lcd_data <= 8'h01;
`else
            r_kind     <= KindLine1;
            r_lcd_data <= 8'h80;
`endif
          end
        end

        StSetup: begin
          r_state <= StEHigh;
          r_lcd_e <= 1'b1;
          r_cnt   <= EHighLoad;
        end

        StEHigh: begin
          if (r_cnt == '0) begin
            r_state <= StGap;
            r_lcd_e <= 1'b0;
            r_cnt   <= GapLoad;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        StGap: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_last) begin
            r_state    <= StDone;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= 8'h00;
`ifdef LCD_STRING_WRITER_CLEAR_EN
          end else if ((r_kind == KindClear) && (CLEAR_WAIT_CYCLES != 0)) begin
            // The clear command needs extra settling time before 0x80.
            r_state <= StClearWait;
            r_cnt   <= ClearLoad;
`endif
          end else begin
            r_state    <= StSetup;
            r_kind     <= w_nxt_kind;
            r_char     <= w_nxt_char;
            r_lcd_rs   <= w_nxt_rs;
            r_lcd_data <= w_nxt_data;
          end
        end

`ifdef LCD_STRING_WRITER_CLEAR_EN
        StClearWait: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state    <= StSetup;
            r_kind     <= w_nxt_kind;
            r_char     <= w_nxt_char;
            r_lcd_rs   <= w_nxt_rs;
            r_lcd_data <= w_nxt_data;
          end
        end
`endif

        // start is deliberately not looked at here.
        StDone: r_state <= StIdle;

        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign io_bus.lcd_e    = r_lcd_e;
  assign io_bus.lcd_rs   = r_lcd_rs;
  assign io_bus.lcd_data = r_lcd_data;
  assign io_bus.lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_string_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_string_writer
// Directed bench for lcd_string_writer. Two instances:
//   dut_a : CHAR_COUNT=4, LINE_LEN=2 (two-line string "ABCD")
//   dut_b : CHAR_COUNT=16, LINE_LEN=16 (single line, reset contents)
// Expected byte streams and cycle positions are built from the string and
// the per-byte cost (1 + 1 + 2 cycles, clear command costing 7 when
// LCD_STRING_WRITER_CLEAR_EN is defined).
// ---------------------------------------------------------------------------
module tb_lcd_string_writer;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  lcd_string_writer_if #(.AW(2)) bus_a ();
  lcd_string_writer_if #(.AW(4)) bus_b ();

  lcd_string_writer #(
    .CHAR_COUNT(4),
    .LINE_LEN(2),
    .E_HIGH_CYCLES(1),
    .GAP_CYCLES(2),
    .CLEAR_WAIT_CYCLES(3)
  ) dut_a (
    .i_clk_1024(clk),
    .i_reset(rst_a),
    .io_bus(bus_a)
  );

  lcd_string_writer #(
    .CHAR_COUNT(16),
    .LINE_LEN(16)
  ) dut_b (
    .i_clk_1024(clk),
    .i_reset(rst_b),
    .io_bus(bus_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] str_q[$];
  logic [7:0] exp_data[$];
  bit         exp_rs[$];
  int         exp_setup[$];
  int         exp_done;

  logic [7:0] got_data[$];
  bit         got_rs[$];
  int         got_setup[$];
  int         done_cnt;
  int         done_rel;
  int         busy_low;
  int         busy_in_done;
  int         rw_hi;
  int         hold_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bytes for str_q on a display with line_len characters per line.
  task automatic build_expected(input int line_len);
    int rel = 1;
    exp_data.delete();
    exp_rs.delete();
    exp_setup.delete();
`ifdef LCD_STRING_WRITER_CLEAR_EN
    exp_data.push_back(8'h01); exp_rs.push_back(1'b0); exp_setup.push_back(rel);
    rel += 7;
`endif
    exp_data.push_back(8'h80); exp_rs.push_back(1'b0); exp_setup.push_back(rel);
    rel += 4;
    for (int i = 0; i < str_q.size(); i++) begin
      if (i == line_len && str_q.size() > line_len) begin
        exp_data.push_back(8'hC0); exp_rs.push_back(1'b0); exp_setup.push_back(rel);
        rel += 4;
      end
      exp_data.push_back(str_q[i]); exp_rs.push_back(1'b1); exp_setup.push_back(rel);
      rel += 4;
    end
    exp_done = rel;
  endtask

  // Called at the negedge right after the start edge (relative cycle 1).
  // Records every byte strobed on the bus, plus done/busy/rw behaviour, and
  // optionally injects a start pulse or a buffer write into dut_a.
  task automatic observe(input int sel, input int maxc, input int poke_rel,
                         input int wr_rel, input logic [7:0] wr_val);
    logic       s_busy, s_done, s_e, s_rs, s_rw;
    logic [7:0] s_data;
    logic       p_e = 1'b0;
    logic       p_rs = 1'b0;
    logic [7:0] p_data = 8'h00;
    got_data.delete();
    got_rs.delete();
    got_setup.delete();
    done_cnt = 0; done_rel = -1; busy_low = 0; busy_in_done = 0; rw_hi = 0; hold_bad = 0;
    for (int rel = 1; rel <= maxc; rel++) begin
      if (sel == 0) begin
        s_busy = bus_a.busy; s_done = bus_a.done; s_e = bus_a.lcd_e;
        s_rs = bus_a.lcd_rs; s_rw = bus_a.lcd_rw; s_data = bus_a.lcd_data;
      end else begin
        s_busy = bus_b.busy; s_done = bus_b.done; s_e = bus_b.lcd_e;
        s_rs = bus_b.lcd_rs; s_rw = bus_b.lcd_rw; s_data = bus_b.lcd_data;
      end
      if (s_e === 1'b1 && p_e !== 1'b1) begin
        got_data.push_back(s_data);
        got_rs.push_back(s_rs);
        got_setup.push_back(rel - 1);
        if (s_data !== p_data || s_rs !== p_rs) hold_bad++;
      end
      if (p_e === 1'b1 && (s_data !== p_data || s_rs !== p_rs)) hold_bad++;
      if (s_done === 1'b1) begin
        done_cnt++;
        if (done_rel < 0) done_rel = rel;
        if (s_busy !== 1'b0) busy_in_done++;
      end
      if (done_rel < 0 && s_busy !== 1'b1) busy_low++;
      if (s_rw !== 1'b0) rw_hi++;
      p_e = s_e; p_rs = s_rs; p_data = s_data;
      bus_a.start   = (rel == poke_rel);
      bus_a.wr_en   = (rel == wr_rel);
      bus_a.wr_addr = 2'd1;
      bus_a.wr_data = wr_val;
      @(negedge clk);
    end
    bus_a.start = 1'b0;
    bus_a.wr_en = 1'b0;
  endtask

  task automatic compare_transfer(input string pfx);
    check({pfx, "_nbytes"}, got_data.size(), exp_data.size());
    for (int n = 0; n < exp_data.size() && n < got_data.size(); n++) begin
      check($sformatf("%s_data%0d", pfx, n), got_data[n], exp_data[n]);
      check($sformatf("%s_rs%0d", pfx, n), got_rs[n], exp_rs[n]);
      check($sformatf("%s_setup%0d", pfx, n), got_setup[n], exp_setup[n]);
    end
    check({pfx, "_done_rel"}, done_rel, exp_done);
    check({pfx, "_done_cnt"}, done_cnt, 1);
    check({pfx, "_busy_low"}, busy_low, 0);
    check({pfx, "_busy_in_done"}, busy_in_done, 0);
    check({pfx, "_rw_high"}, rw_hi, 0);
    check({pfx, "_hold"}, hold_bad, 0);
  endtask

  initial begin
    int w;
    int dn;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.start = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_a_busy", bus_a.busy, 0);
    check("rst_a_done", bus_a.done, 0);
    check("rst_a_e", bus_a.lcd_e, 0);
    check("rst_a_rs", bus_a.lcd_rs, 0);
    check("rst_a_rw", bus_a.lcd_rw, 0);
    check("rst_a_data", bus_a.lcd_data, 8'h00);
    check("rst_b_busy", bus_b.busy, 0);
    check("rst_b_data", bus_b.lcd_data, 8'h00);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Load "ABCD" while idle
    for (int i = 0; i < 4; i++) begin
      bus_a.wr_en   = 1'b1;
      bus_a.wr_addr = 2'(i);
      bus_a.wr_data = 8'h41 + 8'(i);
      @(negedge clk);
    end
    bus_a.wr_en = 1'b0;
    str_q = {8'h41, 8'h42, 8'h43, 8'h44};
    build_expected(2);

    // Transfer 1; start also raised during the DONE cycle, which must not retrigger
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    observe(0, exp_done + 3, exp_done, -1, 8'h00);
    compare_transfer("t1");
    check("t1_idle_busy", bus_a.busy, 0);
    check("t1_idle_data", bus_a.lcd_data, 8'h00);
    check("t1_idle_rs", bus_a.lcd_rs, 0);
    check("t1_idle_e", bus_a.lcd_e, 0);

    // Transfer 2: write 0x5A to addr 1 while busy, second start mid-transfer
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    observe(0, exp_done + 3, 9, 5, 8'h5A);
    compare_transfer("t2");

    // Transfer 3: reset while lcd_e is high, together with start and a write
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    w = 0;
    while (bus_a.lcd_e !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("t3_e_seen", bus_a.lcd_e, 1);
    rst_a = 1'b1;
    bus_a.start = 1'b1;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 2'd0; bus_a.wr_data = 8'h77;
    @(negedge clk);
    rst_a = 1'b0;
    bus_a.start = 1'b0;
    bus_a.wr_en = 1'b0;
    check("t3_abort_e", bus_a.lcd_e, 0);
    check("t3_abort_busy", bus_a.busy, 0);
    check("t3_abort_done", bus_a.done, 0);
    check("t3_abort_data", bus_a.lcd_data, 8'h00);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus_a.done !== 1'b0) dn++;
      @(negedge clk);
    end
    check("t3_no_done", dn, 0);
    check("t3_still_idle", bus_a.busy, 0);

    // Transfer 4: buffer was cleared to spaces by the reset
    str_q = {8'h20, 8'h20, 8'h20, 8'h20};
    build_expected(2);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    observe(0, exp_done + 3, -1, -1, 8'h00);
    compare_transfer("t4");

    // Transfer 5: 16-char single line straight out of reset
    str_q.delete();
    for (int i = 0; i < 16; i++) str_q.push_back(8'h20);
    build_expected(16);
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    observe(1, exp_done + 3, -1, -1, 8'h00);
    compare_transfer("t5");
    check("t5_idle_busy", bus_b.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
